// File: rtl/txform_streamer.sv
// Line streamer: looks up {len, start_addr} for a line, then reads and emits one {lhs, rhs} beat per character.
// Optional macro TXFORM_STREAMER_REVERSE_EN adds a `reverse` input that streams the line from its last character back to its first.
module txform_streamer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6,
    parameter int LINE_W = 6,
    parameter int CHAR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef TXFORM_STREAMER_REVERSE_EN
    input  logic                    reverse,
`endif
    input  logic                    start,
    input  logic [LINE_W-1:0]       line_sel,
    output logic [LINE_W-1:0]       ptr_addr,
    input  logic [LEN_W+ADDR_W-1:0] ptr_data,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [2*CHAR_W-1:0]     mem_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHAR_W-1:0]       out_lhs,
    output logic [CHAR_W-1:0]       out_rhs,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {IDLE, PTR_WAIT, FETCH, MEM_WAIT, OUT, FIN} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic [LEN_W-1:0]  ptr_len;
    logic [ADDR_W-1:0] ptr_start;
    logic [LINE_W-1:0] ptr_addr_q;
    logic              rev_q, rev_in;
    logic              last_beat;

    assign {ptr_len, ptr_start} = ptr_data;
    assign last_beat = (cnt_q == len_q - LEN_W'(1));

`ifdef TXFORM_STREAMER_REVERSE_EN
    assign rev_in = reverse;
`else
    assign rev_in = 1'b0;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = PTR_WAIT;
            PTR_WAIT: state_nxt = (ptr_len == '0) ? FIN : FETCH;
            FETCH:    state_nxt = MEM_WAIT;
            MEM_WAIT: state_nxt = OUT;
            OUT:      if (out_ready) state_nxt = last_beat ? FIN : FETCH;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The line table is addressed combinationally during the start cycle so ptr_data is ready in PTR_WAIT.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        mem_rd_en = (state == FETCH);
        ptr_addr  = (state == IDLE && start) ? line_sel : ptr_addr_q;
        out_last  = out_valid && last_beat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            rev_q      <= 1'b0;
            ptr_addr_q <= '0;
            mem_addr   <= '0;
            out_valid  <= 1'b0;
            out_lhs    <= '0;
            out_rhs    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ptr_addr_q <= line_sel;
                    rev_q      <= rev_in;
                end
                PTR_WAIT: begin
                    len_q <= ptr_len;
                    cnt_q <= '0;
                    if (ptr_len != '0)
                        mem_addr <= rev_q ? ptr_start + ADDR_W'(ptr_len - LEN_W'(1)) : ptr_start;
                end
                MEM_WAIT: begin
                    out_lhs   <= mem_dout[2*CHAR_W-1:CHAR_W];
                    out_rhs   <= mem_dout[CHAR_W-1:0];
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    cnt_q     <= cnt_q + LEN_W'(1);
                    // mem_addr is advanced only when another read follows, so it keeps the last address once idle.
                    if (!last_beat)
                        mem_addr <= rev_q ? mem_addr - ADDR_W'(1) : mem_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_txform_streamer.sv
// Directed bench for txform_streamer: forward, backpressure, len=0, address wrap, mid-line reset, start while busy.
// The reverse-stream case is compiled in when TXFORM_STREAMER_REVERSE_EN is defined.
module tb_txform_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  line_sel = '0;
    logic [5:0]  ptr_addr;
    logic [13:0] ptr_data = '0;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_lhs, out_rhs;
    logic        out_last, busy, done;
`ifdef TXFORM_STREAMER_REVERSE_EN
    logic        reverse = 1'b0;
`endif

    txform_streamer dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TXFORM_STREAMER_REVERSE_EN
        .reverse   (reverse),
`endif
        .start     (start),
        .line_sel  (line_sel),
        .ptr_addr  (ptr_addr),
        .ptr_data  (ptr_data),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lhs   (out_lhs),
        .out_rhs   (out_rhs),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Line table {len, start_addr}; character memory returns {addr, ~addr}.
    logic [13:0] ptr_tab [64];
    always @(posedge clk) ptr_data <= ptr_tab[ptr_addr];
    always @(posedge clk) if (mem_rd_en) mem_dout <= {mem_addr, ~mem_addr};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc, done_cyc, done_cnt;
    logic [7:0]  addr_q [$];
    logic [16:0] beat_q [$];
    int          beat_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) addr_q.push_back(mem_addr);
            if (out_valid && out_ready) begin
                beat_q.push_back({out_lhs, out_rhs, out_last});
                beat_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        addr_q.delete();
        beat_q.delete();
        beat_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic start_line(input logic [5:0] sel, input logic rev);
        start     = 1'b1;
        line_sel  = sel;
`ifdef TXFORM_STREAMER_REVERSE_EN
        reverse   = rev;
`else
        if (rev) $display("reverse requested without TXFORM_STREAMER_REVERSE_EN");
`endif
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    // Expected stream: n reads at a0, a0+step, ... (mod 256); last flag only on the final beat.
    task automatic check_stream(input string tag, input int n, input logic [7:0] a0, input int step);
        logic [7:0] ea;
        check({tag, "_nreads"}, 32'(addr_q.size()), 32'(n));
        check({tag, "_nbeats"}, 32'(beat_q.size()), 32'(n));
        check({tag, "_ndone"},  32'(done_cnt), 32'd1);
        for (int i = 0; i < n; i++) begin
            ea = a0 + 8'(i * step);
            if (i < addr_q.size())
                check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(ea));
            if (i < beat_q.size())
                check($sformatf("%s_beat%0d", tag, i), 32'(beat_q[i]), 32'({ea, ~ea, (i == n - 1)}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ptr_tab[i] = '0;
        ptr_tab[1] = {6'd3, 8'h10};
        ptr_tab[2] = {6'd2, 8'h30};
        ptr_tab[3] = {6'd0, 8'h40};
        ptr_tab[4] = {6'd4, 8'hFE};
        ptr_tab[5] = {6'd5, 8'h50};
        ptr_tab[7] = {6'd3, 8'h20};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_ptr_addr",  32'(ptr_addr),  32'd0);
        check("rst_out_lhs",   32'(out_lhs),   32'd0);
        check("rst_out_rhs",   32'(out_rhs),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Forward stream, ready held high: one beat per 3 cycles, done the cycle after the last beat
        clear_log();
        start_line(6'd1, 1'b0);
        check("fwd_busy_rise", 32'(busy), 32'd1);
        wait_done("fwd");
        check_stream("fwd", 3, 8'h10, 1);
        if (beat_cyc.size() >= 3) begin
            check("fwd_beat_spacing", 32'(beat_cyc[1] - beat_cyc[0]), 32'd3);
            check("fwd_done_lat",     32'(done_cyc - beat_cyc[2]),    32'd1);
        end
        check("fwd_idle_busy",     32'(busy),     32'd0);
        check("fwd_mem_addr_hold", 32'(mem_addr), 32'h12);

        // Backpressure on beat 1 for 5 cycles
        clear_log();
        out_ready = 1'b0;
        start_line(6'd2, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("bp_valid_seen", 32'(seen), 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid_c%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_lhs_c%0d", k),   32'(out_lhs),   32'h30);
            check($sformatf("bp_rhs_c%0d", k),   32'(out_rhs),   32'hCF);
            check($sformatf("bp_rden_c%0d", k),  32'(mem_rd_en), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("bp");
        check_stream("bp", 2, 8'h30, 1);

        // len = 0: no beats, done within 3 cycles of start
        clear_log();
        start_line(6'd3, 1'b0);
        wait_done("len0");
        check("len0_nreads", 32'(addr_q.size()), 32'd0);
        check("len0_nbeats", 32'(beat_q.size()), 32'd0);
        check("len0_done_lat_le3", 32'(done_cyc - start_cyc <= 3), 32'd1);

        // Address wrap past 0xFF
        clear_log();
        start_line(6'd4, 1'b0);
        wait_done("wrap");
        check_stream("wrap", 4, 8'hFE, 1);

        // Reset while beat 2 of 5 is pending
        clear_log();
        start_line(6'd5, 1'b0);
        for (int i = 0; i < 50 && beat_q.size() == 0; i++) @(negedge clk);
        check("mid_beat1_seen", 32'(beat_q.size()), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("mid_beat2_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_last",  32'(out_last),  32'd0);
        check("mid_rst_beats", 32'(beat_q.size()), 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clear_log();
        start_line(6'd5, 1'b0);
        wait_done("restart");
        check_stream("restart", 5, 8'h50, 1);

        // Start pulsed with another line mid-line is ignored
        clear_log();
        start_line(6'd1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start_line(6'd4, 1'b0);
        wait_done("busy_start");
        check_stream("busy_start", 3, 8'h10, 1);
        repeat (8) @(posedge clk);
        #1;
        check("busy_start_no_extra_done", 32'(done_cnt), 32'd1);
        check("busy_start_idle",          32'(busy),     32'd0);

`ifdef TXFORM_STREAMER_REVERSE_EN
        // Reverse stream: 0x22, 0x21, 0x20 with last on the 0x20 beat
        clear_log();
        start_line(6'd7, 1'b1);
        wait_done("rev");
        check_stream("rev", 3, 8'h22, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/txform_streamer.md
TXFORM_STREAMER -- requirements
Module: txform_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: character-memory address width.
REQ-002 SHALL have parameter LEN_W, default 6: line-length field width.
REQ-003 SHALL have parameter LINE_W, default 6: line-select width.
REQ-004 SHALL have parameter CHAR_W, default 8: width of one character.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: start  in  1  start pulse; line_sel  in  LINE_W  line to stream.
REQ-007 SHALL have ports: ptr_addr  out  LINE_W  line-table index; ptr_data  in  LEN_W+ADDR_W  {len, start_addr}.
REQ-008 SHALL have ports: mem_rd_en  out  1  read strobe; mem_addr  out  ADDR_W  read address; mem_dout  in  2*CHAR_W  {lhs, rhs}.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_lhs  out  CHAR_W; out_rhs  out  CHAR_W; out_last  out  1  final beat of line.
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle end-of-line pulse.

Function
REQ-011 Line table and character memory SHALL both be synchronous reads with 1-cycle latency; ptr_data is valid the cycle after ptr_addr is driven, and mem_dout is valid the cycle after mem_rd_en.
REQ-012 States SHALL be IDLE, PTR_WAIT, FETCH, MEM_WAIT, OUT and FIN.
REQ-013 In IDLE, start=1 SHALL drive ptr_addr=line_sel and go to PTR_WAIT; busy rises the next cycle.
REQ-014 In PTR_WAIT the block SHALL latch len and start_addr from ptr_data and clear the beat counter.
REQ-015 From PTR_WAIT, len=0 SHALL go directly to FIN, emitting no beats; otherwise it goes to FETCH.
REQ-016 FETCH SHALL assert mem_rd_en for exactly one cycle, with mem_addr = start_addr + offset mod 2^ADDR_W, then go to MEM_WAIT.
REQ-017 MEM_WAIT SHALL register mem_dout into out_lhs/out_rhs, set out_valid, and go to OUT.
REQ-018 In OUT, out_valid and the data SHALL hold stable until out_ready=1; the handshake then clears out_valid and increments the counter.
REQ-019 After a handshake in OUT, the next state SHALL be FETCH if beats remain, else FIN.
REQ-020 out_last SHALL be 1 exactly when the beat counter equals len-1 while out_valid=1.
REQ-021 FIN SHALL pulse done for one cycle and return to IDLE; busy is 0 in IDLE and 1 in every other state.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 Minimum throughput SHALL be one beat every 3 cycles with out_ready held high.
REQ-024 The beat counter SHALL be LEN_W bits wide; len = 2^LEN_W-1 streams fully without counter overflow.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W; no out-of-range sentinel address is driven.
REQ-026 mem_rd_en SHALL be 0 outside FETCH, and mem_addr holds its last value when idle.

Reset
REQ-027 rst=1 at any clock edge SHALL force IDLE and zero the counters, including mid-line, discarding any pending beat.
REQ-028 Reset values SHALL be: out_valid=0, out_last=0, done=0, busy=0, mem_rd_en=0, mem_addr=0, ptr_addr=0, out_lhs=0, out_rhs=0.

Configuration
REQ-029 Macro TXFORM_STREAMER_REVERSE_EN defined SHALL add input port reverse (1 bit), sampled with start.
REQ-030 With the macro defined and reverse=1, offsets SHALL run from len-1 down to 0, so the first read is start_addr+len-1 (wrapped); out_last still marks the final beat.
REQ-031 Without the macro, the reverse port SHALL be absent and streaming is always forward.

Verification
REQ-032 Forward stream: ptr_data={len=3, start=0x10}, out_ready=1 -> reads at 0x10, 0x11, 0x12; 3 beats; out_last on beat 3; done 1 cycle later.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles on beat 1 -> out_valid, out_lhs and out_rhs stable, no new mem_rd_en, and no beat lost.
REQ-034 Edge cases: len=0 -> no out_valid and done within 3 cycles of start; start=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-035 Mid-line reset: rst on beat 2 of 5 -> next cycle out_valid=0 and busy=0; a fresh start then streams the new line from beat 1.
REQ-036 Start while busy: start pulsed with another line_sel mid-line -> ignored and the current line completes; with REVERSE_EN, reverse=1, len=3, start=0x20 -> reads 0x22, 0x21, 0x20.
